rp_8bit_fetch: RTL

Instruction fetch sequencer for the rp_8bit core. It sits between program memory and the instruction decoder. It prefetches 16-bit words into a 4-word buffer, assembles one- and two-word AVR instructions, and delivers them with their word address over a valid/ready handshake. It also executes the two control-flow requests from the execute stage: redirect (jump/branch/call/return) and skip (cpse/sbrc/sbrs/sbic/sbis).

---
 rtl/rp_8bit_fetch_if.sv | 28 ++
 rtl/rp_8bit_fetch.sv | 107 ++++++++++
 2 files changed

// File: rtl/rp_8bit_fetch_if.sv
// Fetch-side bus of the rp_8bit core: program-memory request port, instruction
// delivery port and the execute-stage redirect/skip requests.
interface rp_8bit_fetch_if #(
    parameter int PAW = 16
);
    logic           pmem_vld;
    logic [PAW-1:0] pmem_adr;
    logic           pmem_rdy;
    logic [15:0]    pmem_rdt;
    logic           ins_vld;
    logic           ins_rdy;
    logic [PAW-1:0] ins_pc;
    logic [31:0]    ins_op;
    logic           ins_len;
    logic           jmp_vld;
    logic [PAW-1:0] jmp_adr;
    logic           skp_vld;

    modport master (
        output pmem_vld, pmem_adr, ins_vld, ins_pc, ins_op, ins_len,
        input  pmem_rdy, pmem_rdt, ins_rdy, jmp_vld, jmp_adr, skp_vld
    );

    modport slave (
        input  pmem_vld, pmem_adr, ins_vld, ins_pc, ins_op, ins_len,
        output pmem_rdy, pmem_rdt, ins_rdy, jmp_vld, jmp_adr, skp_vld
    );
endinterface

// File: rtl/rp_8bit_fetch.sv
// Instruction fetch sequencer: prefetches program words into a 4-word FIFO,
// assembles one/two-word AVR instructions, and handles redirect and skip.
module rp_8bit_fetch #(
    parameter int             PAW      = 16,
    parameter logic [PAW-1:0] RESET_PC = '0
) (
    input logic             clk,
    input logic             rst,
    rp_8bit_fetch_if.master bus
);
    typedef enum logic {RUN, FLUSH} state_t;

    state_t         state;
    logic [15:0]    fifo [4];
    logic [1:0]     rd_ptr;
    logic [2:0]     count;
    logic           inflight;
    logic           skip_pend;
    logic [PAW-1:0] fetch_pc;
    logic [PAW-1:0] head_pc;

    logic [1:0]  rd_ptr1;
    logic [1:0]  wr_idx;
    logic [15:0] word0;
    logic [15:0] word1;
    logic        two_word;
    logic [2:0]  need;
    logic        complete;
    logic        ins_vld;
    logic        handshake;
    logic        skip_do;
    logic [2:0]  pop_n;
    logic        wr;
    logic [2:0]  count_after;
    logic        req;
    logic        accept;

    assign rd_ptr1 = rd_ptr + 2'd1;
    assign wr_idx  = rd_ptr + count[1:0];
    assign word0   = fifo[rd_ptr];
    assign word1   = fifo[rd_ptr1];

    // lds/sts: 1001_00?x_xxxx_0000; jmp/call: 1001_010x_xxxx_11xx
    assign two_word = ((word0[15:10] == 6'b100100) && (word0[3:0] == 4'b0000)) ||
                      ((word0[15:9] == 7'b1001010) && (word0[3:2] == 2'b11));

    assign need      = two_word ? 3'd2 : 3'd1;
    assign complete  = (count >= need);
    assign ins_vld   = complete && !skip_pend && !bus.jmp_vld;
    assign handshake = ins_vld && bus.ins_rdy;
    assign skip_do   = skip_pend && complete && !bus.jmp_vld;
    assign pop_n     = (handshake || skip_do) ? need : 3'd0;

    // The response arriving in FLUSH belongs to the request issued alongside jmp_vld.
    assign wr          = inflight && (state == RUN);
    assign count_after = bus.jmp_vld ? 3'd0 : (count - pop_n + {2'b00, wr});
    assign req         = !rst && (count_after < 3'd4);
    assign accept      = req && bus.pmem_rdy;

    assign bus.pmem_vld = req;
    assign bus.pmem_adr = fetch_pc;
    assign bus.ins_vld  = ins_vld;
    assign bus.ins_pc   = head_pc;
    assign bus.ins_op   = {(two_word ? word1 : 16'h0000), word0};
    assign bus.ins_len  = two_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            rd_ptr    <= 2'd0;
            count     <= 3'd0;
            inflight  <= 1'b0;
            skip_pend <= 1'b0;
            fetch_pc  <= RESET_PC;
            head_pc   <= RESET_PC;
            for (int i = 0; i < 4; i++) begin
                fifo[i] <= 16'h0000;
            end
        end else begin
            state    <= bus.jmp_vld ? FLUSH : RUN;
            inflight <= accept;
            if (bus.jmp_vld) begin
                fetch_pc  <= bus.jmp_adr;
                head_pc   <= bus.jmp_adr;
                rd_ptr    <= 2'd0;
                count     <= 3'd0;
                skip_pend <= 1'b0;
            end else begin
                fetch_pc <= fetch_pc + {{(PAW-1){1'b0}}, accept};
                count    <= count_after;
                if (wr) begin
                    fifo[wr_idx] <= bus.pmem_rdt;
                end
                if (handshake || skip_do) begin
                    rd_ptr  <= rd_ptr + need[1:0];
                    head_pc <= head_pc + PAW'(need);
                end
                // A skip request seen while one is already pending is dropped.
                if (skip_do) begin
                    skip_pend <= 1'b0;
                end else if (bus.skp_vld) begin
                    skip_pend <= 1'b1;
                end
            end
        end
    end
endmodule
